load_store_buffer: RTL and testbench
====================================

LOAD_STORE_BUFFER -- requirements
Module: load_store_buffer

Interface
REQ-001 Parameter DEPTH, default 8, sets the number of entries; it SHALL be a power of two, from 2 to 16.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 alloc_valid  in  1  dispatch writes a new entry at the tail.
REQ-005 alloc_is_store  in  1  1 = store, 0 = load.
REQ-006 alloc_ROBEN  in  5  ROB tag of the instruction.
REQ-007 alloc_imm  in  32  signed address offset.
REQ-008 alloc_base_rdy, alloc_data_rdy  in  1 each  operand already valid.
REQ-009 alloc_base_tag, alloc_data_tag  in  5 each  producer ROB tag when not ready.
REQ-010 alloc_base_val, alloc_data_val  in  32 each  operand value when ready.
REQ-011 cdb_valid  in  1; cdb_ROBEN  in  5; cdb_value  in  32: common-data-bus broadcast.
REQ-012 commit_valid  in  1; commit_ROBEN  in  5: ROB head is retiring this tag.
REQ-013 flush  in  1  synchronous squash of all entries.
REQ-014 full  out  1; empty  out  1; count  out  5: occupancy.
REQ-015 ROBEN  out  5; Read_en  out  1; Write_en  out  1; address  out  32; data  out  32: registered request to the data memory.

Function
REQ-016 The buffer SHALL be a circular FIFO with head and tail pointers plus count; each entry holds is_store, ROBEN, imm, base rdy/tag/val, data rdy/tag/val, and committed.
REQ-017 alloc_valid with full=0 SHALL write the entry at the tail, advance the tail modulo DEPTH, and clear committed; alloc_valid with full=1 SHALL be ignored with no state change.
REQ-018 full and empty SHALL derive from the registered count only; a same-cycle issue SHALL NOT admit an allocation when full=1.
REQ-019 Each posedge with cdb_valid, every valid entry whose non-ready operand tag equals cdb_ROBEN SHALL capture cdb_value and set that ready bit.
REQ-020 An allocating operand that is not ready but whose tag equals a same-cycle cdb_ROBEN with cdb_valid SHALL be stored as ready with cdb_value.
REQ-021 commit_valid SHALL set committed in every valid store entry whose ROBEN equals commit_ROBEN.
REQ-022 Only the head entry SHALL issue; memory operations proceed strictly in program order.
REQ-023 A head load SHALL issue when its base is ready.
REQ-024 A head store SHALL issue when base and data are ready and it is either committed or matched by commit_valid/commit_ROBEN in the same cycle.
REQ-025 On issue, at the next posedge:
- address = base_val + imm, mod 2^32 with wraparound;
- data = data_val for a store, 0 for a load;
- ROBEN = entry tag;
- Read_en = !is_store; Write_en = is_store;
- head advances modulo DEPTH; count decrements.
REQ-026 Read_en and Write_en SHALL be single-cycle pulses, never both 1, and both 0 in any cycle without issue; address, data and ROBEN SHALL hold their last values when idle.
REQ-027 Issue-to-request latency SHALL be one cycle: the head ready at posedge N drives outputs after posedge N, so memory samples them at the following negedge.
REQ-028 Simultaneous alloc and issue SHALL leave count unchanged; with count=0 the allocated entry SHALL NOT issue in the same cycle.
REQ-029 The CDB capture on the head entry SHALL be visible to issue one cycle later, not in the capture cycle.
REQ-030 flush SHALL set head=tail=0, count=0, clear all entries, and force Read_en=Write_en=0; it SHALL take priority over alloc, CDB capture, commit and issue in the same cycle.
REQ-031 Pointer arithmetic SHALL wrap from DEPTH-1 to 0 without losing entries.

Reset
REQ-032 rst=0 SHALL immediately set head=tail=0, count=0, all entry valid/ready/committed bits to 0, full=0, empty=1, Read_en=0, Write_en=0, ROBEN=0, address=0, data=0.
REQ-033 Reset asserted mid-operation SHALL discard every pending entry; the first allocation after release SHALL land at index 0.

Verification
REQ-034 Load path: alloc load ROBEN=3, base ready 100, imm=4 -> next cycle Read_en=1, address=104, ROBEN=3, Write_en=0; one cycle later Read_en=0.
REQ-035 Store gating: alloc store ROBEN=5, base=200, imm=0, data tag 2 not ready; CDB tag 2 value 77; no commit -> no Write_en; commit ROBEN=5 -> next cycle Write_en=1, address=200, data=77.
REQ-036 Ordering: load ROBEN=7 with base not ready at head, ready load ROBEN=8 behind it -> nothing issues until the CDB supplies tag 7; then 7 issues, then 8 one cycle later.
REQ-037 Full/wrap: allocate DEPTH loads with base not ready -> full=1, count=DEPTH, extra alloc ignored; release all via CDB -> DEPTH consecutive Read_en pulses in order; further allocs wrap to index 0.
REQ-038 Flush/reset: 3 pending entries with flush=1 and alloc_valid=1 in the same cycle -> empty=1, count=0, no request; repeat with rst pulsed low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/load_store_buffer.sv
// In-order load/store buffer: a circular queue of memory ops that wake on CDB
// broadcasts and issue one registered request per cycle from the head.
module load_store_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_valid,
    input  logic        alloc_is_store,
    input  logic [4:0]  alloc_ROBEN,
    input  logic [31:0] alloc_imm,
    input  logic        alloc_base_rdy,
    input  logic        alloc_data_rdy,
    input  logic [4:0]  alloc_base_tag,
    input  logic [4:0]  alloc_data_tag,
    input  logic [31:0] alloc_base_val,
    input  logic [31:0] alloc_data_val,
    input  logic        cdb_valid,
    input  logic [4:0]  cdb_ROBEN,
    input  logic [31:0] cdb_value,
    input  logic        commit_valid,
    input  logic [4:0]  commit_ROBEN,
    input  logic        flush,
    output logic        full,
    output logic        empty,
    output logic [4:0]  count,
    output logic [4:0]  ROBEN,
    output logic        Read_en,
    output logic        Write_en,
    output logic [31:0] address,
    output logic [31:0] data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

    typedef struct packed {
        logic        valid;
        logic        is_store;
        logic [4:0]  roben;
        logic [31:0] imm;
        logic        base_rdy;
        logic [4:0]  base_tag;
        logic [31:0] base_val;
        logic        data_rdy;
        logic [4:0]  data_tag;
        logic [31:0] data_val;
        logic        committed;
    } entry_t;

    entry_t          ent_reg [0:DEPTH-1];
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [4:0]      count_reg;
    logic [4:0]      roben_reg;
    logic            read_en_reg;
    logic            write_en_reg;
    logic [31:0]     address_reg;
    logic [31:0]     data_reg;

    logic [DEPTH-1:0] base_wake;
    logic [DEPTH-1:0] data_wake;
    logic [DEPTH-1:0] commit_hit;

    entry_t head_ent;
    entry_t alloc_ent;
    logic   head_commit_now;
    logic   issue;
    logic   do_alloc;

    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == 5'd0);
    assign count = count_reg;

    assign ROBEN    = roben_reg;
    assign Read_en  = read_en_reg;
    assign Write_en = write_en_reg;
    assign address  = address_reg;
    assign data     = data_reg;

    // Per-entry wakeup and commit matching against this cycle's broadcasts.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign base_wake[gi]  = cdb_valid && ent_reg[gi].valid && !ent_reg[gi].base_rdy
                                    && (ent_reg[gi].base_tag == cdb_ROBEN);
            assign data_wake[gi]  = cdb_valid && ent_reg[gi].valid && !ent_reg[gi].data_rdy
                                    && (ent_reg[gi].data_tag == cdb_ROBEN);
            assign commit_hit[gi] = commit_valid && ent_reg[gi].valid && ent_reg[gi].is_store
                                    && (ent_reg[gi].roben == commit_ROBEN);
        end
    endgenerate

    // Issue looks only at registered entry state, so a CDB capture on the head
    // is seen a cycle later, while a same-cycle commit may release a store.
    assign head_ent        = ent_reg[head_reg];
    assign head_commit_now = commit_valid && (head_ent.roben == commit_ROBEN);
    assign issue = !flush && (count_reg != 5'd0) && head_ent.valid && head_ent.base_rdy
                   && (!head_ent.is_store
                       || (head_ent.data_rdy && (head_ent.committed || head_commit_now)));
    assign do_alloc = alloc_valid && !full && !flush;

    always_comb begin
        alloc_ent           = '0;
        alloc_ent.valid     = 1'b1;
        alloc_ent.is_store  = alloc_is_store;
        alloc_ent.roben     = alloc_ROBEN;
        alloc_ent.imm       = alloc_imm;
        alloc_ent.base_tag  = alloc_base_tag;
        alloc_ent.data_tag  = alloc_data_tag;
        alloc_ent.committed = 1'b0;
        if (alloc_base_rdy) begin
            alloc_ent.base_rdy = 1'b1;
            alloc_ent.base_val = alloc_base_val;
        end else if (cdb_valid && (alloc_base_tag == cdb_ROBEN)) begin
            alloc_ent.base_rdy = 1'b1;
            alloc_ent.base_val = cdb_value;
        end
        if (alloc_data_rdy) begin
            alloc_ent.data_rdy = 1'b1;
            alloc_ent.data_val = alloc_data_val;
        end else if (cdb_valid && (alloc_data_tag == cdb_ROBEN)) begin
            alloc_ent.data_rdy = 1'b1;
            alloc_ent.data_val = cdb_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent_reg[i] <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            roben_reg    <= '0;
            read_en_reg  <= 1'b0;
            write_en_reg <= 1'b0;
            address_reg  <= '0;
            data_reg     <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_reg[i] <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            read_en_reg  <= 1'b0;
            write_en_reg <= 1'b0;
        end else begin
            read_en_reg  <= issue && !head_ent.is_store;
            write_en_reg <= issue && head_ent.is_store;
            if (issue) begin
                address_reg <= head_ent.base_val + head_ent.imm;
                data_reg    <= head_ent.is_store ? head_ent.data_val : 32'd0;
                roben_reg   <= head_ent.roben;
                head_reg    <= head_reg + PW'(1);
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (base_wake[i]) begin
                    ent_reg[i].base_rdy <= 1'b1;
                    ent_reg[i].base_val <= cdb_value;
                end
                if (data_wake[i]) begin
                    ent_reg[i].data_rdy <= 1'b1;
                    ent_reg[i].data_val <= cdb_value;
                end
                if (commit_hit[i]) ent_reg[i].committed <= 1'b1;
            end

            if (issue) ent_reg[head_reg].valid <= 1'b0;

            // Tail is never the issuing head: alloc requires !full, issue requires count>0.
            if (do_alloc) begin
                ent_reg[tail_reg] <= alloc_ent;
                tail_reg          <= tail_reg + PW'(1);
            end

            case ({do_alloc, issue})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Randomized and directed check of load_store_buffer against a queue-based
// model of program-ordered memory ops.
module tb_load_store_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0, alloc_is_store = 1'b0;
    logic [4:0]  alloc_ROBEN = '0;
    logic [31:0] alloc_imm = '0;
    logic        alloc_base_rdy = 1'b0, alloc_data_rdy = 1'b0;
    logic [4:0]  alloc_base_tag = '0, alloc_data_tag = '0;
    logic [31:0] alloc_base_val = '0, alloc_data_val = '0;
    logic        cdb_valid = 1'b0;
    logic [4:0]  cdb_ROBEN = '0;
    logic [31:0] cdb_value = '0;
    logic        commit_valid = 1'b0;
    logic [4:0]  commit_ROBEN = '0;
    logic        flush = 1'b0;
    logic        full, empty, Read_en, Write_en;
    logic [4:0]  count, ROBEN;
    logic [31:0] address, data;

    load_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
        .alloc_ROBEN(alloc_ROBEN), .alloc_imm(alloc_imm),
        .alloc_base_rdy(alloc_base_rdy), .alloc_data_rdy(alloc_data_rdy),
        .alloc_base_tag(alloc_base_tag), .alloc_data_tag(alloc_data_tag),
        .alloc_base_val(alloc_base_val), .alloc_data_val(alloc_data_val),
        .cdb_valid(cdb_valid), .cdb_ROBEN(cdb_ROBEN), .cdb_value(cdb_value),
        .commit_valid(commit_valid), .commit_ROBEN(commit_ROBEN),
        .flush(flush),
        .full(full), .empty(empty), .count(count),
        .ROBEN(ROBEN), .Read_en(Read_en), .Write_en(Write_en),
        .address(address), .data(data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        st;
        bit [4:0]  rob;
        bit [31:0] imm;
        bit        brdy;
        bit [4:0]  btag;
        bit [31:0] bval;
        bit        drdy;
        bit [4:0]  dtag;
        bit [31:0] dval;
        bit        cm;
    } ment_t;

    typedef struct {
        bit        rd;
        bit        wr;
        bit [4:0]  rob;
        bit [31:0] addr;
        bit [31:0] dat;
        int        cnt;
    } mout_t;

    ment_t q[$];
    mout_t exp_cur, exp_pend;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model's view of the current outputs.
    always @(negedge clk) begin
        chk("Read_en", Read_en, exp_cur.rd);
        chk("Write_en", Write_en, exp_cur.wr);
        chk("ROBEN", ROBEN, exp_cur.rob);
        chk("address", address, exp_cur.addr);
        chk("data", data, exp_cur.dat);
        chk("count", count, exp_cur.cnt);
        chk("full", full, exp_cur.cnt == DEPTH);
        chk("empty", empty, exp_cur.cnt == 0);
        if (Read_en || Write_en)
            $display("req %s rob=%0d addr=%h data=%h", Write_en ? "WR" : "RD", ROBEN, address, data);
    end

    function automatic void model_reset();
        q.delete();
        exp_cur  = '{default: 0};
        exp_pend = '{default: 0};
    endfunction

    // Effect of the upcoming posedge given the inputs currently driven.
    function automatic void model_step();
        int n0 = q.size();
        ment_t h, e;
        exp_pend.rd = 0;
        exp_pend.wr = 0;
        if (flush) begin
            q.delete();
            exp_pend.cnt = 0;
            return;
        end
        if (n0 > 0) begin
            h = q[0];
            if (h.brdy && (!h.st || (h.drdy && (h.cm || (commit_valid && commit_ROBEN == h.rob))))) begin
                exp_pend.rd   = !h.st;
                exp_pend.wr   = h.st;
                exp_pend.addr = h.bval + h.imm;
                exp_pend.dat  = h.st ? h.dval : 32'd0;
                exp_pend.rob  = h.rob;
                void'(q.pop_front());
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            if (cdb_valid && !e.brdy && e.btag == cdb_ROBEN) begin e.brdy = 1; e.bval = cdb_value; end
            if (cdb_valid && !e.drdy && e.dtag == cdb_ROBEN) begin e.drdy = 1; e.dval = cdb_value; end
            if (commit_valid && e.st && e.rob == commit_ROBEN) e.cm = 1;
            q[i] = e;
        end
        if (alloc_valid && n0 < DEPTH) begin
            e = '{default: 0};
            e.st = alloc_is_store; e.rob = alloc_ROBEN; e.imm = alloc_imm;
            e.btag = alloc_base_tag; e.dtag = alloc_data_tag;
            if (alloc_base_rdy) begin e.brdy = 1; e.bval = alloc_base_val; end
            else if (cdb_valid && alloc_base_tag == cdb_ROBEN) begin e.brdy = 1; e.bval = cdb_value; end
            if (alloc_data_rdy) begin e.drdy = 1; e.dval = alloc_data_val; end
            else if (cdb_valid && alloc_data_tag == cdb_ROBEN) begin e.drdy = 1; e.dval = cdb_value; end
            q.push_back(e);
        end
        exp_pend.cnt = q.size();
    endfunction

    task automatic idle_inputs();
        alloc_valid = 0; cdb_valid = 0; commit_valid = 0; flush = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        exp_cur = exp_pend;
        idle_inputs();
    endtask

    task automatic alloc_op(input bit st, input int rob, input int imm, input bit brdy, input int btag,
                            input int bval, input bit drdy, input int dtag, input int dval);
        alloc_valid = 1; alloc_is_store = st; alloc_ROBEN = 5'(rob); alloc_imm = imm;
        alloc_base_rdy = brdy; alloc_base_tag = 5'(btag); alloc_base_val = bval;
        alloc_data_rdy = drdy; alloc_data_tag = 5'(dtag); alloc_data_val = dval;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // Load path
        alloc_op(0, 3, 4, 1, 0, 100, 0, 0, 0); step();
        step();
        chk("lit_load_rd", Read_en, 1); chk("lit_load_addr", address, 104);
        chk("lit_load_rob", ROBEN, 3); chk("lit_load_wr", Write_en, 0);
        step();
        chk("lit_load_pulse", Read_en, 0);

        // Store gating on data wakeup and commit
        alloc_op(1, 5, 0, 1, 0, 200, 0, 2, 0); step();
        cdb_valid = 1; cdb_ROBEN = 2; cdb_value = 77; step();
        step(); step();
        chk("lit_store_wait", Write_en, 0);
        commit_valid = 1; commit_ROBEN = 5; step();
        chk("lit_store_wr", Write_en, 1); chk("lit_store_addr", address, 200);
        chk("lit_store_data", data, 77);
        step();

        // Program order: blocked head holds back a ready younger load
        alloc_op(0, 7, 8, 0, 20, 0, 0, 0, 0); step();
        alloc_op(0, 8, 0, 1, 0, 50, 0, 0, 0); step();
        step(); step();
        chk("lit_order_blocked", Read_en, 0); chk("lit_order_count", count, 2);
        cdb_valid = 1; cdb_ROBEN = 20; cdb_value = 1000; step();
        chk("lit_order_capture_cycle", Read_en, 0);
        step();
        chk("lit_order_first", ROBEN, 7); chk("lit_order_first_addr", address, 1008);
        step();
        chk("lit_order_second", ROBEN, 8); chk("lit_order_second_rd", Read_en, 1);
        step();

        // Fill, overflow, drain with wrap
        for (int i = 0; i < DEPTH; i++) begin alloc_op(0, i, i * 4, 0, 30, 0, 0, 0, 0); step(); end
        chk("lit_full", full, 1); chk("lit_full_count", count, DEPTH);
        alloc_op(0, 31, 0, 1, 0, 0, 0, 0, 0); step();
        chk("lit_full_ignored", count, DEPTH);
        cdb_valid = 1; cdb_ROBEN = 30; cdb_value = 32'h1000; step();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("lit_drain_rd", Read_en, 1); chk("lit_drain_rob", ROBEN, i);
        end
        alloc_op(0, 12, 2, 1, 0, 32'hFFFF_FFFF, 0, 0, 0); step();
        step();
        chk("lit_wrap_addr", address, 1); chk("lit_wrap_rob", ROBEN, 12);
        step();

        // Flush wins over a same-cycle alloc
        for (int i = 0; i < 3; i++) begin alloc_op(0, i, 0, 0, 25, 0, 0, 0, 0); step(); end
        flush = 1; alloc_op(0, 4, 0, 1, 0, 9, 0, 0, 0); step();
        chk("lit_flush_empty", empty, 1); chk("lit_flush_count", count, 0);
        cdb_valid = 1; cdb_ROBEN = 25; cdb_value = 1; step();
        chk("lit_flush_noreq", Read_en, 0);

        // Asynchronous reset while a request is on the outputs
        alloc_op(0, 6, 0, 0, 26, 0, 0, 0, 0); step();
        alloc_op(0, 9, 16, 1, 0, 64, 0, 0, 0); step();
        alloc_op(0, 10, 0, 0, 27, 0, 0, 0, 0); step();
        cdb_valid = 1; cdb_ROBEN = 26; cdb_value = 3; step();
        step();
        chk("lit_pre_rst_rd", Read_en, 1);
        rst = 0; model_reset(); #1;
        chk("lit_rst_rd", Read_en, 0); chk("lit_rst_addr", address, 0);
        chk("lit_rst_rob", ROBEN, 0); chk("lit_rst_empty", empty, 1);
        @(negedge clk); #1 rst = 1;
        alloc_op(0, 11, 1, 1, 0, 5, 0, 0, 0); step();
        step();
        chk("lit_after_rst_addr", address, 6);
        step();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 55)
                alloc_op($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255) - 128,
                         $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                         $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_ROBEN = 5'($urandom_range(0, 7));
            cdb_value = $urandom;
            commit_valid = ($urandom_range(0, 99) < 40);
            commit_ROBEN = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 99) < 2);
            step();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
